serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder built around a single full-adder cell plus a registered carry.
- Adds two WIDTH-bit operands LSB-first, one bit per clock. Trades latency for area versus the parallel ripple chain of full adders.
- Upstream start/operand interface; downstream consumes sum/cout on a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register, (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock, and rst_n low immediately forces IDLE with busy=0, done=0, sum=0, cout=0, and the internal shift registers, carry and counter cleared.
- Reset asserted mid-operation aborts the addition. No done pulse is produced for the aborted add.
- State machine has three states:
  - IDLE to RUN on start: latch a and b into shift registers, carry<=cin, cnt<=0.
  - RUN: each edge computes s=a_sh[0]^b_sh[0]^carry and c=majority(a_sh[0],b_sh[0],carry). The s bit is shifted into the MSB of the partial-sum register, a_sh and b_sh shift right, carry<=c, cnt<=cnt+1.
  - RUN to DONE on the edge where cnt==WIDTH-1. On that same edge, sum<=final partial sum (including the bit computed that edge) and cout<=c.
  - DONE: done=1 for exactly one cycle, then DONE to IDLE. If start is high in DONE, go straight to RUN with new operands latched (back-to-back adds).
- Latency: start sampled at edge k; done high in the cycle following edge k+WIDTH. Throughput is one add per WIDTH+1 cycles.
- busy is high exactly WIDTH cycles per add.
- start while busy is ignored; the operands in flight are unaffected.
- sum and cout change only on the RUN to DONE edge. They hold the last result through IDLE and the next RUN.
- cnt is ceil(log2(WIDTH+1)) bits wide. WIDTH=1 gives one RUN cycle.
- a, b and cin may change freely outside the accepting edge.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = two's-complement overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - ovf is registered, updated on the same edge as sum and cout, and reset to 0.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 with start=0 -> busy=0, done=0, sum=0x00, cout=0 held indefinitely.
- WIDTH=8, a=0xFF, b=0x01, cin=0, start pulse -> busy high for 8 cycles, done high 8 edges after start, sum=0x00, cout=1.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then back-to-back with start held in DONE: a=0x12, b=0x34, cin=0 -> next done gives sum=0x46, cout=0 with no IDLE cycle between adds.
- Start while busy: a=0x0F, b=0x01 accepted; start pulsed mid-RUN with a=0xFF -> that start is ignored and the result is sum=0x10, cout=0.
- Reset mid-op: start add, drop rst_n after 3 RUN cycles -> immediate busy=0, sum=0, no done. After release, a new add of 0x03+0x04 gives sum=0x07.
- With SERIAL_ADDER_OVF_EN defined: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1. Then a=0x01, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: one full-adder cell plus a registered carry adds two
//   WIDTH-bit operands LSB-first, one bit per clock.
//
//   Parameters
//     WIDTH   operand/sum width, 1..32
//
//   Ports
//     clk     clock, rising edge
//     rst_n   asynchronous active-low reset
//     start   request; accepted in IDLE or DONE only
//     a, b    operands, sampled on the accepting edge
//     cin     carry-in, sampled on the accepting edge
//     busy    high while the add is running (WIDTH cycles)
//     done    one-cycle pulse, sum/cout valid
//     sum     (a+b+cin) mod 2^WIDTH, held until the next result
//     cout    carry out of bit WIDTH-1
//     ovf     two's-complement overflow (only with SERIAL_ADDER_OVF_EN)
//
//   Build option
//     SERIAL_ADDER_OVF_EN  adds the registered ovf output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_d;

  // Full-adder cell on the current LSBs.
  logic             s_bit, c_bit;
  logic [WIDTH:0]   ps_cat;
  logic [WIDTH-1:0] ps_shift;

  assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign c_bit    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  // Built via concatenation so WIDTH=1 needs no special case.
  assign ps_cat   = {s_bit, ps_q};
  assign ps_shift = ps_cat[WIDTH:1];

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    ps_d    = ps_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    // Carry into the top bit is the carry held on the final RUN cycle.
    ovf_d   = carry_q ^ c_bit;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          ps_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        ps_d    = ps_shift;
        carry_d = c_bit;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          sum_d   = ps_shift;
          cout_d  = c_bit;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      ps_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      ps_q    <= ps_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (state_q == S_RUN && cnt_q == LAST)
      ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
`endif

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Last result the DUT should be holding (for the hold-during-RUN check).
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = model(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // One add. gap=1 lets the DUT fall back to IDLE first; gap=0 issues start
  // during the DONE cycle left by the previous add (back-to-back).
  // mid_start pulses start with junk operands partway through RUN.
  task automatic do_add(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input bit gap, input bit mid_start);
    int n, bcnt;
    logic [W:0] exp;
    exp = model(xa, xb, xc);
    if (gap) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".idle_done"}, {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({tag, ".hold_sum"}, {24'd0, sum}, {24'd0, prev_sum});
    chk({tag, ".hold_cout"}, {31'd0, cout}, {31'd0, prev_cout});
    n = 0; bcnt = 0;
    while (!done && n < 100) begin
      if (busy) bcnt++;
      if (mid_start && n == 3) begin
        start = 1'b1; a = '1; b = '1; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, n, W);
    chk({tag, ".busy_cycles"}, bcnt, W);
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".sum"}, {24'd0, sum}, {24'd0, exp[W-1:0]});
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, exp[W]});
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, model_ovf(xa, xb, xc)});
`endif
    prev_sum  = exp[W-1:0];
    prev_cout = exp[W];
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    bit           gap;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1};
    vt[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};  // back-to-back
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1};
    vt[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[7] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1};
    vt[8] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1};
    vt[9] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy}, 0);
    chk("rst.done", {31'd0, done}, 0);
    chk("rst.sum", {24'd0, sum}, 0);
    chk("rst.cout", {31'd0, cout}, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle.busy", {31'd0, busy}, 0);
      chk("idle.done", {31'd0, done}, 0);
      chk("idle.sum", {24'd0, sum}, 0);
      chk("idle.cout", {31'd0, cout}, 0);
    end

    // Table: constants written by hand, cross-checked with the model.
    for (int i = 0; i < 10; i++) begin
      logic [W:0] m;
      m = model(vt[i].a, vt[i].b, vt[i].cin);
      chk("table.model_sum", {24'd0, m[W-1:0]}, {24'd0, vt[i].exp_sum});
      chk("table.model_cout", {31'd0, m[W]}, {31'd0, vt[i].exp_cout});
      do_add($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].gap, 1'b0);
    end

    // Done must be a single-cycle pulse.
    @(posedge clk); #1;
    chk("pulse.done_drop", {31'd0, done}, 0);
    chk("pulse.busy", {31'd0, busy}, 0);

    // Start while busy is ignored.
    do_add("midstart", 8'h0F, 8'h01, 1'b0, 1'b1, 1'b1);
    chk("midstart.sum_const", {24'd0, sum}, 32'h10);

    // Reset mid-operation.
    @(negedge clk); a = 8'h55; b = 8'h66; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'd0, busy}, 0);
    chk("abort.done", {31'd0, done}, 0);
    chk("abort.sum", {24'd0, sum}, 0);
    chk("abort.cout", {31'd0, cout}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("abort.no_done", {31'd0, done}, 0);
    end
    prev_sum = '0; prev_cout = 1'b0;
    do_add("post_abort", 8'h03, 8'h04, 1'b0, 1'b1, 1'b0);
    chk("post_abort.sum_const", {24'd0, sum}, 32'h07);

    // Random operands, random gaps.
    for (int i = 0; i < 40; i++)
      do_add("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
